// File: rtl/lsu_wb_master.sv
// rtl/lsu_wb_master.sv - single-beat Wishbone classic bus master behind the load/store unit
module lsu_wb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_adr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic        lsu_write_enable_i,
  input  logic        lsu_read_enable_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ready_o,
  output logic        lsu_busy_o,
  output logic        lsu_bus_err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Last BUS-cycle count value before the transaction is abandoned.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;

  // Next-state logic: latch in IDLE, wait for ack/err/timeout in BUS, pulse ready in DONE.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    bus_err_d = 1'b0;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (lsu_write_enable_i || lsu_read_enable_i) begin
          adr_d   = lsu_adr_i;
          dat_d   = lsu_dat_i;
          sel_d   = lsu_sel_i;
          // Write takes precedence when both enables are asserted.
          we_d    = lsu_write_enable_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        cnt_d = cnt_q + 16'd1;
        if (wbm_err_i || wbm_ack_i || (cnt_q == TMO_LAST)) begin
          state_d   = ST_DONE;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          busy_d    = 1'b0;
          ready_d   = 1'b1;
          // An ack only counts as success when err is not raised alongside it.
          bus_err_d = wbm_err_i || !wbm_ack_i;
          if (wbm_ack_i && !wbm_err_i && !we_q) begin
            rdata_d = wbm_dat_i;
          end
        end
      end

      ST_DONE: begin
        // Requests seen here are ignored; the requester is still holding the old one.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      bus_err_q <= 1'b0;
      rdata_q   <= 32'd0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      bus_err_q <= bus_err_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_we_o      = we_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = stb_q;
  assign lsu_busy_o    = busy_q;
  assign lsu_ready_o   = ready_q;
  assign lsu_bus_err_o = bus_err_q;
  assign lsu_dat_o     = rdata_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// tb/tb_lsu_wb_master.sv - self-checking bench for lsu_wb_master
module tb_lsu_wb_master;

  localparam int RESP_ACK  = 0;
  localparam int RESP_ERR  = 1;
  localparam int RESP_BOTH = 2;
  localparam int RESP_NONE = 3;
  localparam int NV        = 8;

  typedef struct {
    logic        we_req;
    logic        rd_req;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wait_st;
    int          resp;
    logic [31:0] rdata;
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_rdat;
    int          exp_cyc;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] lsu_adr;
  logic [31:0] lsu_dat;
  logic [3:0]  lsu_sel;
  logic        lsu_write_enable;
  logic        lsu_read_enable;
  logic [31:0] lsu_dat_o;
  logic        lsu_ready_o;
  logic        lsu_busy_o;
  logic        lsu_bus_err_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat;
  logic        wbm_ack;
  logic        wbm_err;

  int   n_cmp;
  int   n_bad;
  int   cycle_no;
  vec_t sb_q[$];
  vec_t vecs[NV];

  lsu_wb_master #(.TIMEOUT(4)) dut (
    .clk_i              (clk),
    .rst_i              (rst_n),
    .lsu_adr_i          (lsu_adr),
    .lsu_dat_i          (lsu_dat),
    .lsu_sel_i          (lsu_sel),
    .lsu_write_enable_i (lsu_write_enable),
    .lsu_read_enable_i  (lsu_read_enable),
    .lsu_dat_o          (lsu_dat_o),
    .lsu_ready_o        (lsu_ready_o),
    .lsu_busy_o         (lsu_busy_o),
    .lsu_bus_err_o      (lsu_bus_err_o),
    .wbm_adr_o          (wbm_adr_o),
    .wbm_dat_o          (wbm_dat_o),
    .wbm_sel_o          (wbm_sel_o),
    .wbm_we_o           (wbm_we_o),
    .wbm_cyc_o          (wbm_cyc_o),
    .wbm_stb_o          (wbm_stb_o),
    .wbm_dat_i          (wbm_dat),
    .wbm_ack_i          (wbm_ack),
    .wbm_err_i          (wbm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic rd, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel, input int ws,
                              input int resp, input logic [31:0] rdata, input logic exp_we,
                              input logic exp_err, input logic [31:0] exp_rdat, input int exp_cyc);
    vec_t v;
    v.we_req   = we;
    v.rd_req   = rd;
    v.adr      = adr;
    v.dat      = dat;
    v.sel      = sel;
    v.wait_st  = ws;
    v.resp     = resp;
    v.rdata    = rdata;
    v.exp_we   = exp_we;
    v.exp_err  = exp_err;
    v.exp_rdat = exp_rdat;
    v.exp_cyc  = exp_cyc;
    return v;
  endfunction

  // Called at a falling edge; drives the request, plays the slave, checks on ready.
  task automatic run_txn(input vec_t v, output int start_cyc);
    int   cc;
    int   guard;
    bit   done;
    vec_t e;
    lsu_write_enable = v.we_req;
    lsu_read_enable  = v.rd_req;
    lsu_adr          = v.adr;
    lsu_dat          = v.dat;
    lsu_sel          = v.sel;
    sb_q.push_back(v);
    cc        = 0;
    guard     = 0;
    done      = 0;
    start_cyc = -1;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
      wbm_ack = 1'b0;
      wbm_err = 1'b0;
      wbm_dat = ~v.rdata;
      if (wbm_cyc_o) begin
        if (cc == 0) begin
          start_cyc = cycle_no;
          check("busy_in_bus", 72'(lsu_busy_o), 72'(1'b1));
        end
        check("bus_fields", 72'({wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o}),
              72'({v.adr, v.dat, v.sel, v.exp_we, 1'b1}));
        if (cc == v.wait_st) begin
          wbm_dat = v.rdata;
          case (v.resp)
            RESP_ACK:  wbm_ack = 1'b1;
            RESP_ERR:  wbm_err = 1'b1;
            RESP_BOTH: begin wbm_ack = 1'b1; wbm_err = 1'b1; end
            default:   ;
          endcase
        end
        cc++;
      end
      if (lsu_ready_o) begin
        done = 1;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard: ready with no expected entry, got 1 expected 0");
        end else begin
          e = sb_q.pop_front();
          check("bus_err", 72'(lsu_bus_err_o), 72'(e.exp_err));
          check("read_data", 72'(lsu_dat_o), 72'(e.exp_rdat));
          check("cyc_cycles", 72'(cc), 72'(e.exp_cyc));
          check("ready_latency", 72'(guard), 72'(e.exp_cyc + 1));
          check("bus_released", 72'({wbm_cyc_o, wbm_stb_o, wbm_we_o, lsu_busy_o}), 72'(0));
          check("fields_held", 72'({wbm_adr_o, wbm_dat_o, wbm_sel_o}), 72'({e.adr, e.dat, e.sel}));
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_wait: no lsu_ready_o within %0d cycles, expected one", guard);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    @(negedge clk);
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    check("ready_pulse", 72'({lsu_ready_o, wbm_cyc_o, lsu_busy_o}), 72'(0));
    lsu_write_enable = 1'b0;
    lsu_read_enable  = 1'b0;
  endtask

  initial begin
    int   s;
    int   prev;
    int   guard;
    vec_t v;

    //                we    rd    adr           dat           sel      ws resp       rdata         we    err   exp_rdat      cyc
    vecs[0] = mk(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 4'b1111, 0, RESP_ACK,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
    vecs[1] = mk(1'b1, 1'b0, 32'h0000_2004, 32'hA5A5_A5A5, 4'b0100, 3, RESP_ACK,  32'h1111_1111, 1'b1, 1'b0, 32'hDEAD_BEEF, 4);
    vecs[2] = mk(1'b1, 1'b1, 32'h0000_3008, 32'h1234_5678, 4'b0011, 1, RESP_ACK,  32'h2222_2222, 1'b1, 1'b0, 32'hDEAD_BEEF, 2);
    vecs[3] = mk(1'b0, 1'b1, 32'h0000_400C, 32'h0000_0000, 4'b1111, 0, RESP_BOTH, 32'h3333_3333, 1'b0, 1'b1, 32'hDEAD_BEEF, 1);
    vecs[4] = mk(1'b0, 1'b1, 32'h0000_5000, 32'h0000_0000, 4'b1111, 0, RESP_NONE, 32'h4444_4444, 1'b0, 1'b1, 32'hDEAD_BEEF, 4);
    vecs[5] = mk(1'b0, 1'b1, 32'h0000_6000, 32'h0000_0000, 4'b1100, 2, RESP_ACK,  32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 3);
    vecs[6] = mk(1'b0, 1'b1, 32'h0000_7001, 32'h0000_0000, 4'b0000, 3, RESP_ACK,  32'h0BAD_C0DE, 1'b0, 1'b0, 32'h0BAD_C0DE, 4);
    vecs[7] = mk(1'b1, 1'b0, 32'h0000_8008, 32'h5555_AAAA, 4'b1001, 2, RESP_ERR,  32'h6666_6666, 1'b1, 1'b1, 32'h0BAD_C0DE, 3);

    n_cmp            = 0;
    n_bad            = 0;
    cycle_no         = 0;
    rst_n            = 1'b0;
    lsu_adr          = 32'd0;
    lsu_dat          = 32'd0;
    lsu_sel          = 4'd0;
    lsu_write_enable = 1'b0;
    lsu_read_enable  = 1'b0;
    wbm_dat          = 32'd0;
    wbm_ack          = 1'b0;
    wbm_err          = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_lo", 72'({wbm_adr_o, wbm_dat_o}), 72'(0));
    check("reset_hi", 72'({wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, lsu_dat_o,
                           lsu_ready_o, lsu_busy_o, lsu_bus_err_o}), 72'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i], s);
    end

    // Back-to-back zero-wait reads: a new cycle starts every third clock.
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      v = mk(1'b0, 1'b1, 32'h0000_9000 + 32'(4 * i), 32'h0, 4'b1111, 0, RESP_ACK,
             32'h7000_0000 + 32'(i), 1'b0, 1'b0, 32'h7000_0000 + 32'(i), 1);
      run_txn(v, s);
      if (i > 0) check("b2b_interval", 72'(s - prev), 72'(3));
      prev = s;
    end

    // Asynchronous reset while the bus cycle is open, then a held read re-issues.
    lsu_read_enable  = 1'b1;
    lsu_write_enable = 1'b0;
    lsu_adr          = 32'h0000_A000;
    lsu_dat          = 32'h0;
    lsu_sel          = 4'b1111;
    guard = 0;
    @(negedge clk);
    while (!wbm_cyc_o && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("rst_seq_cyc_up", 72'(wbm_cyc_o), 72'(1'b1));
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_lo", 72'({wbm_adr_o, wbm_dat_o}), 72'(0));
    check("async_rst_hi", 72'({wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, lsu_dat_o,
                               lsu_ready_o, lsu_busy_o, lsu_bus_err_o}), 72'(0));
    @(negedge clk);
    check("no_ready_in_reset", 72'({lsu_ready_o, wbm_cyc_o}), 72'(0));
    rst_n = 1'b1;
    v = mk(1'b0, 1'b1, 32'h0000_A000, 32'h0, 4'b1111, 1, RESP_ACK,
           32'h5A5A_1234, 1'b0, 1'b0, 32'h5A5A_1234, 2);
    run_txn(v, s);

    check("scoreboard_empty", 72'(sb_q.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_wb_master.md
# lsu_wb_master

Sequential bus-master stage directly downstream of the combinational load/store unit. It accepts the LSU's word-aligned address, replicated write data, byte selects and read/write enables, and runs one single-beat Wishbone classic transaction per request. Read data goes back unmodified to the LSU's `lsu_dat_i` input for extraction and sign extension. It reports completion, bus error and timeout.

## Interface
- `TIMEOUT`, default 255: BUS-state cycles without `ack`/`err` before the transaction is aborted as an error. Legal range 1..65535.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `lsu_adr_i` in 32: word-aligned address from the LSU. Bits [1:0] are forwarded as given.
- `lsu_dat_i` in 32: write data from the LSU, already lane-replicated.
- `lsu_sel_i` in 4: byte-lane selects.
- `lsu_write_enable_i` in 1: write request, level, held until `lsu_ready_o` is sampled high.
- `lsu_read_enable_i` in 1: read request, same rules.
- `lsu_dat_o` out 32: last successfully read bus word, feeds the LSU `lsu_dat_i`.
- `lsu_ready_o` out 1: one-cycle completion pulse, set for both success and error.
- `lsu_busy_o` out 1: high while a request is latched and not yet completed.
- `lsu_bus_err_o` out 1: set together with `lsu_ready_o` when the transaction ended in `wbm_err_i` or timeout.
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_sel_o` out 4, `wbm_we_o` out 1: bus request fields.
- `wbm_cyc_o` out 1, `wbm_stb_o` out 1: bus cycle and strobe.
- `wbm_dat_i` in 32, `wbm_ack_i` in 1, `wbm_err_i` in 1: slave response.

## Operation
- All outputs are registered. Reset (`rst_i`=0) drives every output to 0 and the FSM to IDLE.
- IDLE: if `lsu_write_enable_i` or `lsu_read_enable_i` is high at the clock edge, latch the request and go to BUS:
  - latch `lsu_adr_i` into `wbm_adr_o`, `lsu_dat_i` into `wbm_dat_o`, `lsu_sel_i` into `wbm_sel_o`;
  - set `wbm_we_o` = `lsu_write_enable_i`;
  - set `wbm_cyc_o`, `wbm_stb_o` and `lsu_busy_o` to 1;
  - clear the timeout counter.
- If both enables are high, the write wins. A read with `lsu_sel_i` = 0 is still issued.
- BUS: hold all `wbm_*` outputs stable. The 16-bit timeout counter increments each BUS cycle. Exit rules:
  - `wbm_err_i`=1, or counter == `TIMEOUT`-1 with no `ack`: go to DONE with the error flag set.
  - `wbm_ack_i`=1 (and no `err`): go to DONE. On a read, capture `wbm_dat_i` into `lsu_dat_o`.
  - On either exit, `wbm_cyc_o`, `wbm_stb_o` and `wbm_we_o` drop to 0 and `lsu_busy_o` drops to 0.
  - `err` and `ack` in the same cycle count as an error, and no data is captured.
- DONE (one cycle): `lsu_ready_o`=1 and `lsu_bus_err_o` = error flag. Then return to IDLE unconditionally.
- `lsu_dat_o` changes only on a successful read ack. It holds its value across writes, errors and timeouts.
- `wbm_adr_o`, `wbm_dat_o` and `wbm_sel_o` keep their last values after completion. Only `cyc`/`stb`/`we` return to 0.
- Requests arriving while in BUS or DONE are ignored. The requester holds its enables until it samples `lsu_ready_o`=1, then it may change them.

## Timing
- Request sampled at edge E0. `cyc`/`stb` are high from E0 to the edge where `ack`/`err` is sampled (Ek).
- `lsu_ready_o` and the captured data are valid from Ek until Ek+1.
- The next request is sampled no earlier than Ek+1 (IDLE). Back-to-back throughput is one transaction per (wait + 3) cycles.
- Zero-wait slave (ack in the first BUS cycle): `ready` is high in the 3rd cycle after the request appears.
- Timeout: `cyc` is held for exactly `TIMEOUT` cycles, then `ready`=1 and `bus_err`=1.
- An asynchronous reset mid-BUS drops `cyc`/`stb` immediately, with no `ready` pulse. After reset release, the first edge with a request high starts a fresh transaction.

## Test plan
- Read, zero wait: `lsu_adr_i`=0x0000_1000, `sel`=1111; slave acks the first BUS cycle with 0xDEAD_BEEF → `cyc`/`stb` high 1 cycle, `we`=0, `ready` pulse, `lsu_dat_o`=0xDEAD_BEEF, `bus_err`=0.
- Write, 3 wait states: `adr` 0x0000_2004, `dat` 0xA5A5_A5A5, `sel` 0100 → `wbm_*` stable for 4 cycles, `we`=1, `ready` on the cycle after ack, `lsu_dat_o` unchanged.
- Both enables high → write issued (`wbm_we_o`=1). `err` and `ack` together → `ready`=1, `bus_err`=1, `lsu_dat_o` unchanged.
- Timeout with `TIMEOUT`=4, slave silent → `cyc` high exactly 4 cycles, then `ready`=1 and `bus_err`=1. The next read then completes normally.
- Reset pulse (`rst_i`=0) during BUS → all outputs 0 asynchronously, no `ready`. After release, a held read request re-issues on the first edge.
- Back-to-back reads with zero-wait acks → `cyc` never high in two consecutive transactions without an intervening low cycle; issue interval 3 cycles.
